project_pwm_capture: RTL
========================

Name: project_pwm_capture

Overview:
- Input-capture block, the receiving end of the PWM peripheral's output path.
- Measures an external or looped-back PWM waveform: period and high time, in i_clk cycles, between consecutive rising edges.
- Posts each completed measurement with a one-cycle valid strobe.
- Lets firmware and loopback benches check generator period/duty settings, and can track an external PWM master.

Parameters:
- WIDTH, 16, counter and result width; matches the period register width of the counter blocks.
- SYNC_STAGES, 2, number of synchronizer flops on i_pwm (minimum 2).

Ports:
- i_clk  input  1  system clock
- i_reset_n  input  1  synchronous active-low reset
- i_en  input  1  capture enable; low forces IDLE, results held
- i_clear  input  1  synchronous clear: results, o_overflow and state back to reset values
- i_pwm  input  1  asynchronous PWM waveform under measurement
- o_period  output  WIDTH  last measured period (rise to rise), cycles
- o_high  output  WIDTH  last measured high time (rise to fall), cycles
- o_valid  output  1  one-cycle strobe when o_period/o_high update
- o_overflow  output  1  sticky: a measurement exceeded 2^WIDTH-1 cycles
- o_busy  output  1  high while a measurement is in progress (not IDLE)

Behaviour:
- Clock and reset: single clock i_clk; synchronous active-low reset i_reset_n.
- Reset values: o_period=0, o_high=0, o_valid=0, o_overflow=0, o_busy=0, state IDLE, counter 0, synchronizer flops 0.
- Input path: i_pwm passes SYNC_STAGES flops, then a one-flop delay for edge detection. Rise/fall detection latency is SYNC_STAGES+1 cycles, identical for both edges, so results are unaffected.
- Measurement definition, with r = rise detect cycle, f = fall detect cycle, r' = next rise detect cycle:
  - period = r' - r
  - high = f - r
- Counter: loaded with 1 on the rise-detect cycle; increments each cycle after that.
- States:
  - IDLE: wait for first rising edge; counter held 0. Rise -> HIGH (counter=1). A falling edge in IDLE is ignored.
  - HIGH: counting. Fall -> LOW, latch counter into internal high register. Counter reaching 2^WIDTH-1 with no fall -> OVF.
  - LOW: counting. Rise -> update outputs: o_period = counter, o_high = latched high. Pulse o_valid for one cycle, the cycle after the rise detect. Reload counter=1 and stay measuring (-> HIGH). Counter reaching 2^WIDTH-1 -> OVF.
- Back-to-back measurements: every rising edge both closes one measurement and opens the next; no dead cycle.
- OVF: set o_overflow (sticky), no o_valid, outputs hold previous values. Wait for next rising edge, then go to HIGH with counter=1 (resynchronized).
- Static input: i_pwm stuck at 0 or 1 (0 %/100 % duty) -> OVF after 2^WIDTH-1 cycles; outputs hold.
- i_en low:
  - State -> IDLE, counter 0, o_valid 0; results and o_overflow held.
  - Synchronizer keeps running, so no false edge on re-enable.
  - First measurement after re-enable starts at the next rise.
- i_clear: same priority as reset for results and state (outputs -> 0, IDLE), but synchronizer not cleared. i_clear beats a coincident valid update.
- Minimum pulses:
  - 1-cycle high pulse -> high=1.
  - Minimum measurable period 2.
  - Glitches shorter than one i_clk period may be missed. This is intended, no filtering.
- Priority: i_reset_n > i_clear > !i_en > edge/overflow logic.
- Arithmetic: unsigned WIDTH bits; counter saturates at 2^WIDTH-1 and never wraps.

Decomposition:
- Shared package (project_pwm_pkg): state encodings ST_IDLE, ST_HIGH, ST_LOW, ST_OVF (2 bits); default WIDTH; COUNT_MAX = {WIDTH{1'b1}}.
- One natural sub-module: project_input_sync (SYNC_STAGES synchronizer plus rise/fall pulse outputs), reusable for the external sync input of the slave counter.

Test Plan:
- Reset/idle: hold i_reset_n=0 5 cycles with i_pwm toggling -> all outputs 0; release with i_pwm=0 -> o_busy=0, no o_valid.
- Steady PWM high 3 / low 5 cycles for 4 periods -> 3 o_valid pulses, each o_period=8, o_high=3; o_overflow=0; o_valid exactly one cycle, 8 cycles apart.
- Duty change mid-stream, high 2/low 6, then high 7/low 1 -> results (8,2) then (8,7); transition period reports the actual rise-to-rise value (8) with its actual high time.
- Overflow, WIDTH=8: i_pwm rises then stays high 300 cycles -> o_overflow=1 at counter 255, no o_valid, results held. Then period 10 / high 4 -> o_valid with (10,4), o_overflow stays 1 until i_clear.
- i_en/i_clear: deassert i_en mid-HIGH -> o_busy=0, results held, no o_valid. Re-enable -> first o_valid one full period after the first new rise. Pulse i_clear coincident with a closing rise -> outputs 0, no o_valid.
- Loopback: drive i_pwm from the slave period counter in UP mode with period 99, plus a duty comparator at 25 -> o_period=100, o_high matches comparator high time every period.

Source files
------------

// File: rtl/project_pwm_pkg.sv
// ---------------------------------------------------------------------------
// project_pwm_pkg
// Shared definitions for the PWM capture path: the capture FSM state
// encoding, the default counter width and its saturation value.
// Ports: none (package only).
// ---------------------------------------------------------------------------
package project_pwm_pkg;

    // Default counter/result width, matching the period register of the
    // counter blocks.
    localparam int DEFAULT_WIDTH = 16;

    // Saturation value of a DEFAULT_WIDTH counter. Instances with a
    // different WIDTH derive their own all-ones value locally.
    localparam logic [DEFAULT_WIDTH-1:0] COUNT_MAX = {DEFAULT_WIDTH{1'b1}};

    // Capture FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2,
        ST_OVF  = 2'd3
    } captureState_t;

endpackage

// File: rtl/project_input_sync.sv
// ---------------------------------------------------------------------------
// project_input_sync
// Brings an asynchronous level into the i_clk domain through SYNC_STAGES
// flops, then compares against a one-flop delayed copy to produce
// single-cycle rise and fall pulses. Both pulses see the same latency, so
// durations measured between them are exact.
// Ports:
//   i_clk      system clock
//   i_reset_n  synchronous active-low reset (clears all flops)
//   i_async    asynchronous input level
//   o_rise     one-cycle pulse on a synchronized 0->1 transition
//   o_fall     one-cycle pulse on a synchronized 1->0 transition
// ---------------------------------------------------------------------------
module project_input_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_async,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_delay;
    logic                   w_synced;

    // Synchronizer chain plus the edge-detect delay flop. Only reset clears
    // these; a capture clear leaves them alone so a level already present on
    // the input is not mistaken for a new edge afterwards.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_sync  <= '0;
            r_delay <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_delay <= w_synced;
        end
    end

    assign w_synced = r_sync[SYNC_STAGES-1];

    // Edge pulses: synchronized level differs from its delayed copy.
    assign o_rise = w_synced & ~r_delay;
    assign o_fall = ~w_synced & r_delay;

endmodule

// File: rtl/project_pwm_capture.sv
// ---------------------------------------------------------------------------
// project_pwm_capture
// Input-capture block for the PWM output path. Measures period (rise to
// rise) and high time (rise to fall) of i_pwm in i_clk cycles and posts each
// completed measurement with a one-cycle o_valid strobe. Every rising edge
// closes one measurement and opens the next, so back-to-back periods are
// measured without gaps.
// Ports:
//   i_clk       system clock
//   i_reset_n   synchronous active-low reset
//   i_en        capture enable; low parks the FSM in IDLE, results held
//   i_clear     synchronous clear of results, overflow flag and state
//   i_pwm       asynchronous PWM waveform under measurement
//   o_period    last measured period, cycles
//   o_high      last measured high time, cycles
//   o_valid     one-cycle strobe when o_period/o_high update
//   o_overflow  sticky flag: a measurement ran past 2^WIDTH-1 cycles
//   o_busy      high while a measurement is in progress
// ---------------------------------------------------------------------------
module project_pwm_capture
    import project_pwm_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_en,
    input  logic             i_clear,
    input  logic             i_pwm,
    output logic [WIDTH-1:0] o_period,
    output logic [WIDTH-1:0] o_high,
    output logic             o_valid,
    output logic             o_overflow,
    output logic             o_busy
);

    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    captureState_t    r_state;
    captureState_t    w_nextState;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_highLatch;
    logic [WIDTH-1:0] r_period;
    logic [WIDTH-1:0] r_high;
    logic             r_valid;
    logic             r_overflow;

    logic             w_rise;
    logic             w_fall;
    logic             w_atMax;
    logic             w_loadCount;
    logic             w_countRun;
    logic             w_latchHigh;
    logic             w_publish;
    logic             w_setOvf;
    logic             w_busy;

    project_input_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_inputSync (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_async   (i_pwm),
        .o_rise    (w_rise),
        .o_fall    (w_fall)
    );

    assign w_atMax = (r_count == CNT_MAX);

    // State register. Reset and clear both return to IDLE; a disabled block
    // also parks in IDLE so the first measurement after re-enable starts
    // cleanly at the next rising edge.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n || i_clear || !i_en) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. A fall in IDLE or OVF carries no information and is
    // ignored; only a rising edge can start a measurement. A fall at the
    // saturation cycle still counts as a valid high time.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_rise) w_nextState = ST_HIGH;
            end
            ST_HIGH: begin
                if (w_fall)       w_nextState = ST_LOW;
                else if (w_atMax) w_nextState = ST_OVF;
            end
            ST_LOW: begin
                if (w_rise)       w_nextState = ST_HIGH;
                else if (w_atMax) w_nextState = ST_OVF;
            end
            ST_OVF: begin
                if (w_rise) w_nextState = ST_HIGH;
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    // Output/control decode. Any rise outside HIGH reloads the counter to 1,
    // which both opens a fresh measurement and resynchronizes after OVF. Only
    // a rise in LOW has a complete period to publish.
    always_comb begin
        w_loadCount = 1'b0;
        w_countRun  = 1'b0;
        w_latchHigh = 1'b0;
        w_publish   = 1'b0;
        w_setOvf    = 1'b0;
        w_busy      = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                w_loadCount = w_rise;
            end
            ST_HIGH: begin
                w_countRun  = 1'b1;
                w_latchHigh = w_fall;
                w_setOvf    = !w_fall && w_atMax;
            end
            ST_LOW: begin
                w_countRun  = 1'b1;
                w_loadCount = w_rise;
                w_publish   = w_rise;
                w_setOvf    = !w_rise && w_atMax;
            end
            ST_OVF: begin
                w_loadCount = w_rise;
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
    end

    // Measurement datapath. The counter saturates rather than wrapping, so a
    // stuck input drives it to CNT_MAX and into OVF. Results and the sticky
    // overflow flag survive a disable; only reset or clear zero them, and a
    // clear wins over a coincident publish.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n || i_clear) begin
            r_count     <= '0;
            r_highLatch <= '0;
            r_period    <= '0;
            r_high      <= '0;
            r_valid     <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (!i_en) begin
            r_count <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_publish;
            if (w_loadCount) begin
                r_count <= CNT_ONE;
            end else if (w_countRun) begin
                if (!w_atMax) r_count <= r_count + CNT_ONE;
            end else begin
                r_count <= '0;
            end
            if (w_latchHigh) r_highLatch <= r_count;
            if (w_publish) begin
                r_period <= r_count;
                r_high   <= r_highLatch;
            end
            if (w_setOvf) r_overflow <= 1'b1;
        end
    end

    assign o_period   = r_period;
    assign o_high     = r_high;
    assign o_valid    = r_valid;
    assign o_overflow = r_overflow;
    assign o_busy     = w_busy;

endmodule
